// File: rtl/vector_load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_load_unit
//  Description : Multi-cycle load stage feeding the register file write port.
//                Fetches one scalar word or LANES strided words, one per
//                memory handshake, into a lane buffer and issues a single
//                one-cycle write. Element i lands in lane LANES-1-i.
//  Options     : VLOAD_TIMEOUT_EN - abort a load after TIMEOUT consecutive
//                stall cycles on one word.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_load_unit #(
    parameter int LANES   = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          is_vector,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             stride,
    input  logic [3:0]                    dest_reg,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          we3,
    output logic [3:0]                    ra3,
    output logic [LANES-1:0][DATA_W-1:0]  wd3,
    output logic                          selec_v_s_w
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [ADDR_W-1:0]           stride_q, stride_d;
    logic                        vec_q, vec_d;
    logic [3:0]                  dst_q, dst_d;
    logic                        rej_q, rej_d;     // rejected scalar-to-r15 request
    logic                        abort_w;
    logic                        last_w;
    logic [IDX_W-1:0]            lane_w;

    // A zero timeout would abort every stalled word immediately; nothing is
    // built here for a legal value.
    if (TIMEOUT < 1) begin : g_timeout_range
    end

`ifdef VLOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q, wait_d;

    // The abort fires on the stall cycle that would bring the counter to TIMEOUT.
    assign abort_w = (state_q == S_FETCH) && !mem_valid
                     && (wait_q == CNT_W'(TIMEOUT - 1));

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_q <= '0;
        else      wait_q <= wait_d;
    end
`else
    assign abort_w = 1'b0;
`endif

    // Element 0 goes to the top lane (scalar slot), element i to lane LANES-1-i.
    assign lane_w = IDX_W'(LANES - 1) - idx_q;
    assign last_w = vec_q ? (idx_q == IDX_W'(LANES - 1)) : (idx_q == '0);

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        lanes_d  = lanes_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        vec_d    = vec_q;
        dst_d    = dst_q;
        rej_d    = 1'b0;
`ifdef VLOAD_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!is_vector && (dest_reg == 4'hF)) begin
                        // r15 is the scalar slot of the vector file: refuse.
                        rej_d = 1'b1;
                    end else begin
                        vec_d    = is_vector;
                        dst_d    = dest_reg;
                        stride_d = stride;
                        addr_d   = base_addr;
                        lanes_d  = '0;
                        idx_d    = '0;
                        state_d  = S_FETCH;
`ifdef VLOAD_TIMEOUT_EN
                        wait_d   = '0;
`endif
                    end
                end
            end
            S_FETCH: begin
                if (mem_valid) begin
                    lanes_d[lane_w] = mem_rdata;
                    idx_d           = idx_q + 1'b1;
                    addr_d          = addr_q + stride_q;
`ifdef VLOAD_TIMEOUT_EN
                    wait_d          = '0;
`endif
                    if (last_w) state_d = S_WRITE;
                end else begin
`ifdef VLOAD_TIMEOUT_EN
                    if (abort_w) begin
                        wait_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        wait_d  = wait_q + 1'b1;
                    end
`endif
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any load in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            lanes_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            vec_q    <= 1'b0;
            dst_q    <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lanes_q  <= lanes_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            vec_q    <= vec_d;
            dst_q    <= dst_d;
            rej_q    <= rej_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_req     = (state_q == S_FETCH);
    assign mem_addr    = mem_req ? addr_q : '0;
    assign we3         = (state_q == S_WRITE);
    assign ra3         = we3 ? dst_q : 4'd0;
    assign selec_v_s_w = we3 & vec_q;
    assign wd3         = we3 ? lanes_q : '0;
    assign done        = we3 | rej_q | abort_w;
    assign err         = rej_q | abort_w;

endmodule
`default_nettype wire

// File: tb/tb_vector_load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_load_unit
//  Description : Self-checking bench for vector_load_unit. A transaction-level
//                model predicts addresses, the assembled lane image and the
//                write cycle from each load's parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_load_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               is_vector;
    logic [31:0]        base_addr;
    logic [31:0]        stride;
    logic [3:0]         dest_reg;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_rdata;
    logic               mem_valid;
    logic               busy;
    logic               done;
    logic               err;
    logic               we3;
    logic [3:0]         ra3;
    logic [15:0][31:0]  wd3;
    logic               selec_v_s_w;

    int tests_run    = 0;
    int tests_failed = 0;

    vector_load_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_vector   (is_vector),
        .base_addr   (base_addr),
        .stride      (stride),
        .dest_reg    (dest_reg),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .we3         (we3),
        .ra3         (ra3),
        .wd3         (wd3),
        .selec_v_s_w (selec_v_s_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete load. vmode: 0 valid every cycle, 1 valid every third
    // fetch cycle, 2 random. dmode: 0 random data, 1 addr>>2, 2 0xDEADBEEF.
    // exp_lat > 0 also checks the start-to-write distance in cycles.
    task automatic run_load(input logic vec, input logic [3:0] dst,
                            input logic [31:0] base, input logic [31:0] strd,
                            input int vmode, input int dmode, input int exp_lat);
        logic [15:0][31:0] exp_wd;
        logic [31:0]       ea;
        logic [31:0]       data;
        logic              v;
        int                n;
        int                k;
        int                cyc;
        n      = vec ? 16 : 1;
        exp_wd = '0;
        start = 1'b1; is_vector = vec; dest_reg = dst; base_addr = base; stride = strd;
        tick();
        start = 1'b0;
        if (!vec && dst == 4'hF) begin
            check("rej_done",  done, 1);
            check("rej_err",   err, 1);
            check("rej_req",   mem_req, 0);
            check("rej_we3",   we3, 0);
            check("rej_busy",  busy, 0);
            tick();
            check("rej_done_clr", done, 0);
            check("rej_req2",     mem_req, 0);
            return;
        end
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 2000) begin
            cyc++;
            ea = base + strd * 32'(k);
            check("f_busy", busy, 1);
            check("f_req",  mem_req, 1);
            check("f_addr", mem_addr, ea);
            check("f_we3",  we3, 0);
            check("f_done", done, 0);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            case (dmode)
                1:       data = ea >> 2;
                2:       data = 32'hDEADBEEF;
                default: data = $urandom;
            endcase
            mem_valid = v;
            mem_rdata = data;
            // Unrelated request while busy; must be ignored.
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; is_vector = $urandom_range(0, 1) == 1;
                dest_reg = 4'($urandom); base_addr = $urandom; stride = $urandom;
            end
            if (v) begin
                exp_wd[15 - k] = data;
                k++;
            end
            tick();
            mem_valid = 1'b0;
            start     = 1'b0;
        end
        if (cyc >= 2000) begin
            check("fetch_bound", 1, 0);
            return;
        end
        check("w_we3",  we3, 1);
        check("w_ra3",  ra3, dst);
        check("w_sel",  selec_v_s_w, vec);
        check("w_wd3",  wd3, exp_wd);
        check("w_done", done, 1);
        check("w_err",  err, 0);
        check("w_req",  mem_req, 0);
        if (exp_lat > 0) check("latency", cyc + 1, exp_lat);
        // start in the exit cycle of WRITE must not be taken.
        start = 1'b1; is_vector = 1'b1; dest_reg = 4'd1;
        tick();
        start = 1'b0;
        check("i_busy", busy, 0);
        check("i_we3",  we3, 0);
        check("i_wd3",  wd3, 0);
        check("i_done", done, 0);
        tick();
        check("i_busy2", busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; is_vector = 1'b0; base_addr = '0; stride = '0;
        dest_reg = '0; mem_rdata = '0; mem_valid = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_req",  mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_we3",  we3, 0);
        check("rst_done", done, 0);
        check("rst_err",  err, 0);
        check("rst_wd3",  wd3, 0);
        rst = 1'b1;
        tick();

        // Directed loads.
        run_load(1'b0, 4'd3, 32'h40, 32'h0, 0, 2, 2);
        run_load(1'b1, 4'd2, 32'h100, 32'h4, 0, 1, 17);
        run_load(1'b1, 4'd7, 32'h8, 32'hFFFFFFFC, 1, 0, 49);
        run_load(1'b0, 4'hF, 32'h20, 32'h0, 0, 0, 0);

        // Reset in the middle of a vector load, after seven captures.
        start = 1'b1; is_vector = 1'b1; dest_reg = 4'd5; base_addr = 32'h200; stride = 32'h4;
        tick();
        start = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1234;
        repeat (7) tick();
        #2 rst = 1'b0;
        #1;
        check("mr_req",  mem_req, 0);
        check("mr_busy", busy, 0);
        check("mr_we3",  we3, 0);
        mem_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_valid = 1'b0;
        check("late_busy", busy, 0);
        check("late_we3",  we3, 0);
        check("late_req",  mem_req, 0);
        tick();
        check("late_we3b", we3, 0);
        run_load(1'b0, 4'd9, 32'h300, 32'h0, 0, 0, 2);

        // Randomized loads.
        for (int i = 0; i < 25; i++) begin
            run_load($urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom, 2, 0, 0);
        end

        // Stalled fetch.
        start = 1'b1; is_vector = 1'b1; dest_reg = 4'd4; base_addr = 32'h500; stride = 32'h8;
        tick();
        start = 1'b0; mem_valid = 1'b0;
`ifdef VLOAD_TIMEOUT_EN
        for (int c = 1; c < 64; c++) begin
            check("to_req",  mem_req, 1);
            check("to_done", done, 0);
            tick();
        end
        check("to_done64", done, 1);
        check("to_err64",  err, 1);
        check("to_we3",    we3, 0);
        tick();
        check("to_idle", busy, 0);
        check("to_req0", mem_req, 0);
        check("to_we3b", we3, 0);
`else
        for (int c = 0; c < 100; c++) begin
            check("st_busy", busy, 1);
            check("st_req",  mem_req, 1);
            check("st_done", done, 0);
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("st_rec", busy, 0);
`endif
        run_load(1'b1, 4'd6, 32'h1000, 32'h10, 0, 1, 17);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
